// File: rtl/bitwise_logic_unit_seq_pkg.sv
// Shared encodings for the multi-cycle bitwise logic unit:
// operation codes and FSM states.
package bitwise_logic_unit_seq_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_logic_unit_seq_slice.sv
// Combinational CHUNK-bit logic slice shared by every chunk of a run.
module logic_slice
    import bitwise_logic_unit_seq_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [1:0]       op,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = '0;
        unique case (1'b1)
            (op == LOGIC_AND): y = a & b;
            (op == LOGIC_OR):  y = a | b;
            (op == LOGIC_XOR): y = a ^ b;
            (op == LOGIC_NOR): y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit, CHUNK bits per clock,
// start/ready handshake shared with the multdiv unit.
module bitwise_logic_unit_seq
    import bitwise_logic_unit_seq_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ctrl_start,
    input  logic [1:0]      ctrl_op,
    input  logic [SIZE-1:0] data_operandA,
    input  logic [SIZE-1:0] data_operandB,
    output logic [SIZE-1:0] data_result,
    output logic            data_resultRDY,
    output logic            result_zero,
    output logic            busy
);

    localparam int NCHUNK = SIZE / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (SIZE % CHUNK != 0) begin : g_bad_param
        $error("bitwise_logic_unit_seq: SIZE must be a multiple of CHUNK");
    end

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            last;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] opa;
    logic [SIZE-1:0] opb;
    logic [1:0]      op;
    logic [SIZE-1:0] work;
    logic [SIZE-1:0] work_full;
    logic [31:0]     base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] y_c;

    if (NCHUNK == 1) begin : g_one
        assign cnt  = '0;
        assign last = 1'b1;
    end else begin : g_cnt
        logic [CW-1:0] cnt_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign cnt  = cnt_q;
        assign last = (cnt_q == CW'(NCHUNK - 1));
    end

    // Chunk selection by shifting keeps the index width-clean.
    assign base = 32'(cnt) * 32'(CHUNK);
    assign a_c  = CHUNK'(opa >> base);
    assign b_c  = CHUNK'(opb >> base);

    logic_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a  (a_c),
        .b  (b_c),
        .op (op),
        .y  (y_c)
    );

    always_comb begin
        work_full = work & ~(SIZE'({CHUNK{1'b1}}) << base);
        work_full = work_full | (SIZE'(y_c) << base);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ctrl_start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opa         <= '0;
            opb         <= '0;
            op          <= LOGIC_AND;
            work        <= '0;
            data_result <= '0;
            result_zero <= 1'b1;
        end else begin
            if (accept) begin
                opa <= data_operandA;
                opb <= data_operandB;
                op  <= ctrl_op;
            end
            if (state_q == RUN) begin
                work <= work_full;
                if (last) begin
                    data_result <= work_full;
                    result_zero <= (work_full == '0);
                end
            end
        end
    end

    assign busy           = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE);

endmodule

// File: doc/bitwise_logic_unit_seq.md
Name: bitwise_logic_unit_seq

Overview:
Multi-cycle, parametrised bitwise logic unit for the ALU datapath, replacing the fixed 32-bit single-function OR array. It computes AND/OR/XOR/NOR of two SIZE-bit operands, CHUNK bits per clock, under a start/ready handshake. The handshake matches the multdiv unit's convention, so the processor stall logic treats both units identically. The result is held stable in an output register until the next completion.

Parameters:
SIZE, 32, operand/result width; must be a multiple of CHUNK.
CHUNK, 8, bits processed per cycle; CHUNK = SIZE gives single-cycle operation.
(derived) NCHUNK = SIZE/CHUNK; CW = max(1, clog2(NCHUNK)) is the chunk counter width.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
ctrl_start  input  1  request; sampled only when busy = 0.
ctrl_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR; latched with the operands.
data_operandA  input  SIZE  operand A; latched on accepted start.
data_operandB  input  SIZE  operand B; latched on accepted start.
data_result  output  SIZE  last completed result; stable between completions.
data_resultRDY  output  1  one-cycle pulse; data_result was updated on this cycle's opening edge.
result_zero  output  1  high when data_result == 0; updated with data_result.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, counter = 0, working reg = 0, data_result = 0, data_resultRDY = 0, result_zero = 1, busy = 0. An in-flight operation is discarded and produces no RDY pulse.
- States: IDLE, RUN, DONE. busy = (state == RUN). data_resultRDY = (state == DONE), registered.
- IDLE or DONE with ctrl_start = 1 at edge k: latch A, B and op; counter = 0; go to RUN.
- IDLE with ctrl_start = 0: stay in IDLE.
- DONE with ctrl_start = 0: go to IDLE.
- RUN, edge k+1+i (i = 0..NCHUNK-1): working[i*CHUNK +: CHUNK] = op(A chunk, B chunk); counter increments.
  - At i = NCHUNK-1: data_result = full working value, including the chunk computed this edge.
  - result_zero updates at the same edge.
  - State goes to DONE.
- Latency: start sampled at edge k gives data_resultRDY high from edge k+NCHUNK to edge k+NCHUNK+1. This is 4 cycles at the defaults.
- Back-to-back: a start asserted during the DONE cycle is accepted. Throughput is therefore one result per NCHUNK+1 cycles.
- ctrl_start while busy is ignored, not queued. Operand and op changes while busy have no effect.
- data_result never shows partial results; only the working register is written chunk-wise.
- NOR is computed as ~(A|B) per chunk. There is no carry or cross-chunk dependency.
- NCHUNK = 1: RUN lasts one cycle, and the counter is a 1-bit signal tied to 0.
- Illegal parameters (SIZE % CHUNK != 0) fail elaboration through a generate-time check.

Decomposition:
- Shared package/include: op encodings LOGIC_AND = 2'b00, LOGIC_OR = 2'b01, LOGIC_XOR = 2'b10, LOGIC_NOR = 2'b11; state encodings IDLE, RUN, DONE.
- One sub-module: logic_slice #(CHUNK), purely combinational (a, b, op -> y). It is instantiated once and fed the counter-selected chunk.
- FSM, counter and registers stay in the top level.

Test Plan:
- Reset mid-run: start OR, A = 0xFFFF0000, B = 0x0000FFFF; assert reset at the 2nd RUN cycle. Required: data_result = 0, result_zero = 1, busy = 0, no RDY pulse. A subsequent run completes normally.
- Per-op check, A = 0xF0F0F0F0, B = 0xFF00FF00, defaults:
  - AND -> 0xF000F000
  - OR -> 0xFFF0FFF0
  - XOR -> 0x0FF00FF0
  - NOR -> 0x000F000F
  - In each case RDY is high exactly 4 cycles after the start edge, for 1 cycle.
- Zero flag and stability: AND with A = 0xAAAAAAAA, B = 0x55555555 -> data_result = 0, result_zero = 1. A new start with changed operands keeps data_result = 0 until the next RDY.
- Busy collision: start XOR; 1 cycle later assert start with other operands. The second request is ignored, the first result is correct, and only one RDY pulse occurs.
- Back-to-back: assert start again during the RDY cycle. Required: second RDY exactly 5 cycles after the first, second result correct.
- Parameter sweep: (SIZE, CHUNK) = (32, 32), (32, 1), (16, 4), random ops and operands checked against a reference model. Latency must equal SIZE/CHUNK cycles.
